// File: rtl/vga_avl_writer.sv
// vga_avl_writer: flushes a game-state snapshot and board rows to a VGA slave over Avalon-MM
module vga_avl_writer #(
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter int          NUM_ROWS  = 20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] LEVEL_LINES,
    input  logic [31:0] SCORE,
    input  logic [4:0]  NEXT_ID,
    input  logic        PAL_VALID,
    input  logic [31:0] PALETTE,
    output logic [4:0]  ROW_RD_ADDR,
    input  logic [19:0] ROW_RD_DATA,
    output logic        AVL_WRITE,
    output logic        AVL_READ,
    output logic        AVL_CS,
    output logic [3:0]  AVL_BYTE_EN,
    output logic [11:0] AVL_ADDR,
    output logic [31:0] AVL_WRITEDATA,
    input  logic        AVL_WAITREQUEST,
    output logic        BUSY,
    output logic        DONE
);
    localparam int IW = $clog2(NUM_ROWS + 4);
    localparam logic [IW-1:0] ROW_LO  = IW'(2);
    localparam logic [IW-1:0] ROW_HI  = IW'(NUM_ROWS + 1);
    localparam logic [IW-1:0] NID_IDX = IW'(NUM_ROWS + 2);
    localparam logic [IW-1:0] PAL_IDX = IW'(NUM_ROWS + 3);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FETCH, ST_DONE} state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_inc, last;
    logic [31:0]   ll_q, score_q, pal_q, wdata;
    logic [4:0]    nid_q, row_addr;
    logic          pal_v_q, accept, next_row;

    assign idx_inc     = idx + 1'b1;
    assign last        = pal_v_q ? PAL_IDX : NID_IDX;
    assign accept      = (state == ST_WRITE) && !AVL_WAITREQUEST;
    assign next_row    = (idx_inc >= ROW_LO) && (idx_inc <= ROW_HI);
    assign ROW_RD_ADDR = row_addr;
    assign AVL_READ    = 1'b0;
    assign wdata       = (idx == '0)     ? ll_q :
                         (idx == IW'(1)) ? score_q :
                         (idx <= ROW_HI) ? {12'b0, ROW_RD_DATA} :
                         (idx == NID_IDX) ? {27'b0, nid_q} : pal_q;

    // State register; reset abandons any in-flight write immediately
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Snapshot capture, word index and row address presented to the row source
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ll_q     <= '0;
            score_q  <= '0;
            nid_q    <= '0;
            pal_v_q  <= 1'b0;
            pal_q    <= '0;
            idx      <= '0;
            row_addr <= '0;
        end else if (state == ST_IDLE && START) begin
            ll_q    <= LEVEL_LINES;
            score_q <= SCORE;
            nid_q   <= NEXT_ID;
            pal_v_q <= PAL_VALID;
            pal_q   <= PALETTE;
            idx     <= '0;
        end else if (accept && idx != last) begin
            idx <= idx_inc;
            if (next_row) row_addr <= 5'(idx_inc - ROW_LO);
        end
    end

    // Next state and bus outputs; outputs are only non-zero while a write is presented
    always_comb begin
        state_next    = state;
        AVL_WRITE     = 1'b0;
        AVL_CS        = 1'b0;
        AVL_BYTE_EN   = 4'b0000;
        AVL_ADDR      = 12'h000;
        AVL_WRITEDATA = 32'h0;
        BUSY          = 1'b0;
        DONE          = 1'b0;
        case (state)
            ST_IDLE:  state_next = START ? ST_WRITE : ST_IDLE;
            ST_FETCH: begin
                BUSY       = 1'b1;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                BUSY          = 1'b1;
                AVL_WRITE     = 1'b1;
                AVL_CS        = 1'b1;
                AVL_BYTE_EN   = 4'b1111;
                AVL_ADDR      = (idx == PAL_IDX) ? 12'h800 : BASE_ADDR + 12'(idx);
                AVL_WRITEDATA = wdata;
                if (!AVL_WAITREQUEST)
                    state_next = (idx == last) ? ST_DONE : next_row ? ST_FETCH : ST_WRITE;
            end
            default: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_vga_avl_writer.sv
// tb_vga_avl_writer: randomized self-checking bench for vga_avl_writer against a word-list model
module tb_vga_avl_writer;
    localparam logic [11:0] BASE = 12'h000;
    localparam int NR = 20;

    logic        CLK = 1'b0, RESET, START, PAL_VALID, AVL_WAITREQUEST;
    logic [31:0] LEVEL_LINES, SCORE, PALETTE;
    logic [4:0]  NEXT_ID, ROW_RD_ADDR;
    logic [19:0] ROW_RD_DATA;
    logic        AVL_WRITE, AVL_READ, AVL_CS, BUSY, DONE;
    logic [3:0]  AVL_BYTE_EN;
    logic [11:0] AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;

    vga_avl_writer #(.BASE_ADDR(BASE), .NUM_ROWS(NR)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .LEVEL_LINES(LEVEL_LINES), .SCORE(SCORE),
        .NEXT_ID(NEXT_ID), .PAL_VALID(PAL_VALID), .PALETTE(PALETTE), .ROW_RD_ADDR(ROW_RD_ADDR),
        .ROW_RD_DATA(ROW_RD_DATA), .AVL_WRITE(AVL_WRITE), .AVL_READ(AVL_READ), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_WAITREQUEST(AVL_WAITREQUEST), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    logic [19:0] rows [0:31];
    always @(posedge CLK) ROW_RD_DATA <= rows[ROW_RD_ADDR];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0, done_cyc = 0, mode = 0, stall_cnt = 0, stall_len = 0, stall_total = 0;
    logic [11:0] stall_addr = 12'h000;
    logic done_seen = 1'b0, prev_stall = 1'b0;
    logic [11:0] prev_addr;
    logic [31:0] prev_data;
    logic [11:0] exp_addr[$], obs_addr[$];
    logic [31:0] exp_data[$], obs_data[$];
    int obs_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: decide waitrequest, then observe the bus away from the rising edge
    task automatic tick();
        @(negedge CLK);
        START = 1'b0;
        cyc++;
        AVL_WAITREQUEST = 1'b0;
        if (mode == 1 && AVL_WRITE) AVL_WAITREQUEST = ($urandom_range(0, 3) == 0);
        if (mode == 2 && AVL_WRITE && AVL_ADDR == stall_addr && stall_cnt < stall_len) begin
            AVL_WAITREQUEST = 1'b1;
            stall_cnt++;
        end
        if (AVL_WAITREQUEST) stall_total++;
        check("read_low", AVL_READ, 0);
        if (prev_stall) check("hold", {AVL_WRITE, AVL_ADDR, AVL_WRITEDATA}, {1'b1, prev_addr, prev_data});
        if (!AVL_WRITE) check("idle_out", {AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA}, 0);
        else            check("wr_ctl", {AVL_CS, AVL_BYTE_EN}, 5'h1F);
        if (AVL_WRITE && !AVL_WAITREQUEST) begin
            obs_addr.push_back(AVL_ADDR);
            obs_data.push_back(AVL_WRITEDATA);
            obs_cyc.push_back(cyc - t0);
        end
        if (DONE) begin
            done_seen = 1'b1;
            done_cyc  = cyc - t0;
        end
        prev_stall = AVL_WRITE && AVL_WAITREQUEST;
        prev_addr  = AVL_ADDR;
        prev_data  = AVL_WRITEDATA;
    endtask

    task automatic rand_inputs();
        LEVEL_LINES = $urandom;
        SCORE       = $urandom;
        NEXT_ID     = 5'($urandom);
        PALETTE     = $urandom;
        PAL_VALID   = 1'($urandom_range(0, 1));
        for (int i = 0; i < NR; i++) rows[i] = 20'($urandom);
    endtask

    // Reference: the ordered list of (address, data) words a flush must produce
    task automatic build_exp();
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i <= NR + 2; i++) begin
            exp_addr.push_back(BASE + 12'(i));
            exp_data.push_back(i == 0 ? LEVEL_LINES : i == 1 ? SCORE :
                               i <= NR + 1 ? {12'b0, rows[i-2]} : {27'b0, NEXT_ID});
        end
        if (PAL_VALID) begin
            exp_addr.push_back(12'h800);
            exp_data.push_back(PALETTE);
        end
    endtask

    function automatic int exp_cycle(input int i);
        return i < 2 ? i + 1 : i <= NR + 1 ? 2 * i : i + NR + 1;
    endfunction

    task automatic run_flush(input string tag, input logic hook);
        logic [31:0] sc0;
        int n0, n;
        build_exp();
        sc0 = SCORE;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        stall_cnt = 0;
        stall_total = 0;
        done_seen = 1'b0;
        t0 = cyc;
        START = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (hook && cyc - t0 == 5) SCORE = ~SCORE;
            if (hook && cyc - t0 == 10) START = 1'b1;
            if (DONE) check({tag, ":busy_done"}, BUSY, 0);
            else      check({tag, ":busy"}, BUSY, 1);
        end while (!done_seen && n < 300);
        check({tag, ":done_seen"}, done_seen, 1);
        check({tag, ":done_cyc"}, done_cyc, 2 * NR + 4 + int'(PAL_VALID) + stall_total);
        check({tag, ":n_writes"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s:addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s:data[%0d]", tag, i), obs_data[i], exp_data[i]);
            if (mode == 0) check($sformatf("%s:cyc[%0d]", tag, i), obs_cyc[i], exp_cycle(i));
        end
        if (hook) check({tag, ":orig_score"}, obs_data.size() > 1 ? obs_data[1] : 32'h0, sc0);
        tick();
        check({tag, ":done_pulse"}, {DONE, BUSY}, 0);
        n0 = obs_addr.size();
        repeat (4) tick();
        check({tag, ":no_extra"}, obs_addr.size(), n0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rows[i] = '0;
        RESET = 1'b1; START = 1'b0; AVL_WAITREQUEST = 1'b0; PAL_VALID = 1'b0;
        LEVEL_LINES = '0; SCORE = '0; NEXT_ID = '0; PALETTE = '0;
        repeat (3) tick();
        check("rst_state", {BUSY, DONE, ROW_RD_ADDR, AVL_WRITE, AVL_CS}, 0);
        RESET = 1'b0;
        repeat (2) tick();

        rand_inputs();
        SCORE = 32'h00012345; NEXT_ID = 5'h06; PAL_VALID = 1'b0;
        rows[0] = 20'hAAAAA; rows[NR-1] = 20'h00003;
        mode = 0;
        run_flush("nowait", 1'b0);
        check("nowait:done44", done_cyc, 44);
        check("nowait:score", obs_data.size() > 1 ? obs_data[1] : 32'h0, 32'h00012345);
        check("nowait:row0", obs_data.size() > 2 ? obs_data[2] : 32'h0, 32'h000AAAAA);
        check("nowait:row19", obs_data.size() > 21 ? obs_data[21] : 32'h0, 32'h00000003);
        check("nowait:nid", obs_data.size() > 22 ? {obs_addr[22], obs_data[22]} : 44'h0, {12'h016, 32'h6});

        rand_inputs();
        PAL_VALID = 1'b0;
        mode = 2; stall_addr = BASE + 12'd5; stall_len = 3;
        run_flush("wait5", 1'b0);
        check("wait5:done47", done_cyc, 47);
        check("wait5:acc_cyc", obs_cyc.size() > 5 ? obs_cyc[5] : 0, 13);

        rand_inputs();
        PAL_VALID = 1'b1; PALETTE = 32'h01FFE1E0;
        mode = 0;
        run_flush("pal", 1'b0);
        check("pal:done45", done_cyc, 45);
        check("pal:word24", obs_data.size() > 23 ? {obs_addr[23], obs_data[23]} : 44'h0, {12'h800, 32'h01FFE1E0});

        rand_inputs();
        run_flush("restart", 1'b1);

        rand_inputs();
        mode = 2; stall_addr = BASE + 12'd9; stall_len = 1000; stall_cnt = 0;
        tick();
        t0 = cyc;
        START = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(AVL_WRITE && AVL_ADDR == BASE + 12'd9) && n < 100);
        check("rst:reach_row7", {AVL_WRITE, AVL_WAITREQUEST, AVL_ADDR}, {2'b11, BASE + 12'd9});
        #2 RESET = 1'b1;
        prev_stall = 1'b0;
        #1 check("rst:async", {AVL_WRITE, AVL_CS, BUSY, AVL_ADDR, AVL_WRITEDATA, ROW_RD_ADDR}, 0);
        mode = 0;
        repeat (2) tick();
        RESET = 1'b0;
        obs_addr.delete();
        repeat (8) tick();
        check("rst:no_write", obs_addr.size(), 0);
        rand_inputs();
        run_flush("after_rst", 1'b0);

        for (int k = 0; k < 6; k++) begin
            rand_inputs();
            mode = 1;
            run_flush($sformatf("rnd%0d", k), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_avl_writer.md
VGA_AVL_WRITER -- requirements
Module: vga_avl_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h000: word address of level/lines register in the VGA slave map.
REQ-002 SHALL have parameter NUM_ROWS, default 20: board rows flushed per frame update.
REQ-003 SHALL have port CLK, input, 1: single clock for all logic.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port START, input, 1: request to flush one snapshot, sampled on CLK rising edge.
REQ-006 SHALL have port LEVEL_LINES, input, 32: [31:16] level BCD, [15:0] line count BCD.
REQ-007 SHALL have port SCORE, input, 32: 8-digit BCD score.
REQ-008 SHALL have port NEXT_ID, input, 5: next-piece identifier.
REQ-009 SHALL have port PAL_VALID, input, 1: palette word is to be written this flush.
REQ-010 SHALL have port PALETTE, input, 32: palette register value.
REQ-011 SHALL have port ROW_RD_ADDR, output, 5: board row index presented to the row source.
REQ-012 SHALL have port ROW_RD_DATA, input, 20: 10 x 2-bit block templates; valid one cycle after ROW_RD_ADDR changes, stable while it is held.
REQ-013 SHALL have ports AVL_WRITE, AVL_READ, AVL_CS (output, 1), AVL_BYTE_EN (output, 4), AVL_ADDR (output, 12), AVL_WRITEDATA (output, 32), AVL_WAITREQUEST (input, 1): Avalon-MM master.
REQ-014 SHALL have ports BUSY and DONE, output, 1: flush in progress; one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, WRITE, FETCH, DONE.
REQ-016 In IDLE, START=1 SHALL latch LEVEL_LINES, SCORE, NEXT_ID, PAL_VALID and PALETTE into snapshot registers, clear word index idx to 0, and enter WRITE.
REQ-017 Word sequence SHALL be: idx 0 snapshot LEVEL_LINES; idx 1 snapshot SCORE; idx 2..NUM_ROWS+1 row idx-2; idx NUM_ROWS+2 {27'b0, NEXT_ID}; then, if PAL_VALID was latched, the palette word.
REQ-018 AVL_ADDR SHALL be BASE_ADDR + idx, 12-bit wrap, for all non-palette words; the palette word SHALL go to 12'h800.
REQ-019 Row words SHALL be written as {12'b0, ROW_RD_DATA}.
REQ-020 Before each row word, the block SHALL spend exactly one FETCH cycle with ROW_RD_ADDR = idx-2, and SHALL hold ROW_RD_ADDR through the following WRITE.
REQ-021 In WRITE, AVL_WRITE=AVL_CS=1 and AVL_BYTE_EN=4'b1111, with AVL_ADDR and AVL_WRITEDATA held stable.
REQ-022 A write SHALL be accepted on a cycle with AVL_WAITREQUEST=0; while it is 1, all master outputs SHALL be held.
REQ-023 On acceptance, the block SHALL advance to the next word (FETCH if row, else WRITE), or to DONE after the last word.
REQ-024 DONE SHALL last one cycle with DONE=1, then return to IDLE.
REQ-025 AVL_READ SHALL be constant 0.
REQ-026 Outside WRITE, AVL_WRITE and AVL_CS SHALL be 0, and AVL_ADDR and AVL_WRITEDATA SHALL be 0.
REQ-027 BUSY SHALL be 1 in WRITE and FETCH, and 0 otherwise.
REQ-028 START SHALL be ignored outside IDLE; requests are not queued.
REQ-029 Input changes after the START cycle SHALL NOT affect the current flush; row data excepted.
REQ-030 With AVL_WAITREQUEST always 0 and START at cycle 0: writes SHALL occur in cycles 1, 2, 4, 6, ..., 42, 43, with DONE in cycle 44. With palette, DONE SHALL be in cycle 45.

Reset
REQ-031 RESET=1 SHALL immediately force IDLE, with all outputs 0 and snapshot registers, idx and ROW_RD_ADDR cleared, including mid-write; any in-flight write is abandoned.
REQ-032 After RESET deasserts, no write SHALL occur until a new START.

Verification
REQ-033 No-wait flush, SCORE=32'h00012345, NEXT_ID=5'h06 -> 23 writes at 0x000..0x016 in order, score word 32'h00012345 at 0x001, 32'h6 at 0x016, DONE at cycle 44.
REQ-034 AVL_WAITREQUEST=1 for 3 cycles on the idx-5 write -> address 0x005 and its data held for 4 cycles, no skipped or duplicated words, DONE at cycle 47.
REQ-035 PAL_VALID=1, PALETTE=32'h01FFE1E0 -> 24th write at 0x800 with data 32'h01FFE1E0, DONE at cycle 45.
REQ-036 START pulsed again at cycle 10; SCORE changed at cycle 5 -> no second flush, original score written at 0x001.
REQ-037 RESET asserted during row-7 write under waitrequest -> AVL_WRITE=0 in the same cycle, BUSY=0; a fresh START restarts from 0x000.
REQ-038 Row source returns 20'hAAAAA for row 0 and 20'h00003 for row 19 -> 0x002 receives 32'h000AAAAA and 0x015 receives 32'h00000003.
